// File: rtl/sched_pkg.sv
// Shared types and constants for the channel round-robin scheduler.
package sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } sched_state_t;

  localparam int GCNT_W = 16;

  // Ceiling log2, never below 1 so single-entry ranges still get a bit.
  function automatic int idx_w(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request strictly after ptr, wrapping at CHANNEL.
module rr_pick
  import sched_pkg::*;
#(
  parameter int CHANNEL = 5,
  localparam int IDX_W = idx_w(CHANNEL)
) (
  input  logic [CHANNEL-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   win_idx,
  output logic               any
);

  int               c;
  logic [IDX_W-1:0] cand;

  // Offset 1..CHANNEL visits ptr last, so the previous winner gets lowest priority.
  always_comb begin
    win_idx = '0;
    any     = 1'b0;
    c       = 0;
    cand    = '0;
    for (int i = 1; i <= CHANNEL; i++) begin
      c    = (int'(ptr) + i) % CHANNEL;
      cand = IDX_W'(c);
      if (!any && req[cand]) begin
        any     = 1'b1;
        win_idx = cand;
      end
    end
  end

endmodule

// File: rtl/chan_rr_scheduler.sv
// Round-robin scheduler feeding one shared datapath through valid/ready,
// with a post-transfer hold window and a wrapping transfer counter.
module chan_rr_scheduler
  import sched_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int CHANNEL = 5,
  parameter int HOLD    = 3,
  localparam int IDX_W  = idx_w(CHANNEL)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CHANNEL-1:0]       req,
  input  logic [CHANNEL*WIDTH-1:0] req_data,
  output logic [CHANNEL-1:0]       gnt,
  output logic                     dp_valid,
  output logic [WIDTH-1:0]         dp_data,
  output logic [IDX_W-1:0]         dp_chan,
  input  logic                     dp_ready,
  output logic                     busy,
  output logic [GCNT_W-1:0]        grant_cnt
);

  localparam int HC_W = idx_w(HOLD);

  generate
    if (CHANNEL < 2 || CHANNEL > 16) begin : g_bad_channel
      $error("chan_rr_scheduler: CHANNEL must be in 2..16");
    end
    if (HOLD < 1) begin : g_bad_hold
      $error("chan_rr_scheduler: HOLD must be at least 1");
    end
  endgenerate

  sched_state_t     state;
  logic [IDX_W-1:0] ptr;
  logic [HC_W-1:0]  hcnt;
  logic [IDX_W-1:0] win_idx;
  logic             any;
  logic [WIDTH-1:0] chan_data [CHANNEL];

  for (genvar g = 0; g < CHANNEL; g++) begin : g_unpack
    assign chan_data[g] = req_data[g*WIDTH +: WIDTH];
  end

  rr_pick #(
    .CHANNEL (CHANNEL)
  ) u_pick (
    .req     (req),
    .ptr     (ptr),
    .win_idx (win_idx),
    .any     (any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= IDX_W'(CHANNEL - 1);
      gnt       <= '0;
      dp_valid  <= 1'b0;
      dp_data   <= '0;
      dp_chan   <= '0;
      busy      <= 1'b0;
      grant_cnt <= '0;
      hcnt      <= '0;
    end else begin
      gnt <= '0;
      case (state)
        ST_IDLE: begin
          if (any) begin
            dp_data  <= chan_data[win_idx];
            dp_chan  <= win_idx;
            dp_valid <= 1'b1;
            gnt      <= CHANNEL'(1) << win_idx;
            ptr      <= win_idx;
            busy     <= 1'b1;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (dp_ready) begin
            dp_valid  <= 1'b0;
            grant_cnt <= grant_cnt + GCNT_W'(1);
            hcnt      <= HC_W'(HOLD - 1);
            state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // Counter runs HOLD-1 down to 0, so this state spans exactly HOLD cycles.
          if (hcnt == '0) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            hcnt <= hcnt - HC_W'(1);
          end
        end
        default: begin
          busy     <= 1'b0;
          dp_valid <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chan_rr_scheduler.sv
// Directed bench for chan_rr_scheduler (WIDTH=32, CHANNEL=5, HOLD=3).
module tb_chan_rr_scheduler;

  localparam int WIDTH   = 32;
  localparam int CHANNEL = 5;
  localparam int HOLD    = 3;
  localparam int IDX_W   = 3;

  logic                     clk;
  logic                     rst;
  logic [CHANNEL-1:0]       req;
  logic [CHANNEL*WIDTH-1:0] req_data;
  logic [CHANNEL-1:0]       gnt;
  logic                     dp_valid;
  logic [WIDTH-1:0]         dp_data;
  logic [IDX_W-1:0]         dp_chan;
  logic                     dp_ready;
  logic                     busy;
  logic [15:0]              grant_cnt;

  int checks;
  int failures;

  chan_rr_scheduler #(
    .WIDTH   (WIDTH),
    .CHANNEL (CHANNEL),
    .HOLD    (HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .dp_valid  (dp_valid),
    .dp_data   (dp_data),
    .dp_chan   (dp_chan),
    .dp_ready  (dp_ready),
    .busy      (busy),
    .grant_cnt (grant_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [CHANNEL-1:0] exp_gnt;
    logic               stable;
    int                 n;
    checks   = 0;
    failures = 0;

    // Reset held with random requests
    rst      = 1'b1;
    dp_ready = 1'b0;
    req      = CHANNEL'($urandom);
    for (int i = 0; i < CHANNEL; i++) req_data[i*WIDTH +: WIDTH] = $urandom;
    #10;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_valid", 32'(dp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(grant_cnt), 32'd0);
    chk("rst_data", dp_data, 32'd0);
    @(negedge clk);
    req = '0;
    rst = 1'b0;
    tick();

    // Single request on channel 2
    req_data[2*WIDTH +: WIDTH] = 32'habcdefab;
    req      = 5'b00100;
    dp_ready = 1'b1;
    tick();
    chk("single_gnt", 32'(gnt), 32'h4);
    chk("single_valid", 32'(dp_valid), 32'd1);
    chk("single_data", dp_data, 32'habcdefab);
    chk("single_chan", 32'(dp_chan), 32'd2);
    req = '0;
    tick();
    chk("single_gnt_pulse", 32'(gnt), 32'd0);
    chk("single_valid_drop", 32'(dp_valid), 32'd0);
    chk("single_cnt", 32'(grant_cnt), 32'd1);
    tick();
    tick();
    chk("single_busy_k3", 32'(busy), 32'd1);
    tick();
    chk("single_busy_k4", 32'(busy), 32'd0);

    // Mid-cycle asynchronous reset pulse clears the counter without a clock edge
    #2 rst = 1'b1;
    #1;
    chk("async_rst_cnt", 32'(grant_cnt), 32'd0);
    #1 rst = 1'b0;
    tick();

    // Round robin with everyone requesting
    for (int i = 0; i < CHANNEL; i++) req_data[i*WIDTH +: WIDTH] = 32'h1000_0000 + i;
    req      = 5'b11111;
    dp_ready = 1'b1;
    for (int g = 0; g < 6; g++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (gnt == '0 && n < 20);
      exp_gnt = CHANNEL'(1) << (g % CHANNEL);
      chk("rr_gnt", 32'(gnt), 32'(exp_gnt));
      chk("rr_chan", 32'(dp_chan), 32'(g % CHANNEL));
      chk("rr_data", dp_data, 32'h1000_0000 + 32'(g % CHANNEL));
      if (g > 0) chk("rr_spacing", 32'(n), 32'd5);
    end
    tick();
    req = '0;
    chk("rr_cnt", 32'(grant_cnt), 32'd6);
    wait_idle();

    // Backpressure on channel 1
    req_data[1*WIDTH +: WIDTH] = 32'h12345678;
    dp_ready = 1'b0;
    req      = 5'b00010;
    tick();
    chk("bp_gnt", 32'(gnt), 32'h2);
    req    = '0;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (dp_valid !== 1'b1 || dp_data !== 32'h12345678 || dp_chan !== 3'd1) stable = 1'b0;
    end
    chk("bp_stable", 32'(stable), 32'd1);
    chk("bp_cnt_held", 32'(grant_cnt), 32'd6);
    dp_ready = 1'b1;
    tick();
    chk("bp_valid_drop", 32'(dp_valid), 32'd0);
    chk("bp_cnt", 32'(grant_cnt), 32'd7);
    for (int i = 0; i < 6; i++) tick();
    chk("bp_one_xfer", 32'(grant_cnt), 32'd7);
    chk("bp_idle", 32'(busy), 32'd0);

    // Reset while channel 3 is in ISSUE
    dp_ready = 1'b0;
    req_data[3*WIDTH +: WIDTH] = 32'h0000_0333;
    req_data[4*WIDTH +: WIDTH] = 32'h0000_0444;
    req = 5'b01000;
    tick();
    chk("mid_gnt", 32'(gnt), 32'h8);
    req = 5'b11000;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(dp_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    chk("mid_rst_valid_hold", 32'(dp_valid), 32'd0);
    chk("mid_rst_cnt", 32'(grant_cnt), 32'd0);
    #3 rst = 1'b0;
    dp_ready = 1'b1;
    tick();
    chk("mid_regrant", 32'(gnt), 32'h8);
    chk("mid_chan", 32'(dp_chan), 32'd3);
    chk("mid_data", dp_data, 32'h0000_0333);
    req = 5'b10000;
    n = 0;
    do begin
      tick();
      n++;
    end while (gnt == '0 && n < 20);
    chk("mid_next_gnt", 32'(gnt), 32'h10);
    chk("mid_next_spacing", 32'(n), 32'd5);
    req = '0;
    wait_idle();
    chk("final_cnt", 32'(grant_cnt), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
